// File: rtl/tl_bank_request_buffer.sv
// TileLink-UL buffer ahead of the bank binder: registered A and D queues plus an outstanding-request cap.
// Optional performance counters are enabled by defining TL_BANK_BUFFER_PERF_EN.
module tl_bank_request_buffer #(
    parameter int A_DEPTH      = 2,
    parameter int D_DEPTH      = 2,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [7:0]  auto_in_a_bits_source,
    input  logic [32:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [7:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_denied,
    output logic        auto_in_d_bits_corrupt,
    output logic [63:0] auto_in_d_bits_data,
    input  logic        auto_out_a_ready,
    output logic        auto_out_a_valid,
    output logic [2:0]  auto_out_a_bits_opcode,
    output logic [2:0]  auto_out_a_bits_param,
    output logic [2:0]  auto_out_a_bits_size,
    output logic [7:0]  auto_out_a_bits_source,
    output logic [32:0] auto_out_a_bits_address,
    output logic [7:0]  auto_out_a_bits_mask,
    output logic [63:0] auto_out_a_bits_data,
    output logic        auto_out_d_ready,
    input  logic        auto_out_d_valid,
    input  logic [2:0]  auto_out_d_bits_opcode,
    input  logic [1:0]  auto_out_d_bits_param,
    input  logic [2:0]  auto_out_d_bits_size,
    input  logic [7:0]  auto_out_d_bits_source,
    input  logic        auto_out_d_bits_sink,
    input  logic        auto_out_d_bits_denied,
    input  logic        auto_out_d_bits_corrupt,
    input  logic [63:0] auto_out_d_bits_data,
`ifdef TL_BANK_BUFFER_PERF_EN
    output logic [31:0] perf_a_stall_cycles,
    output logic [31:0] perf_inflight_cap_cycles,
`endif
    output logic [7:0]  inflight_count
);
    localparam int AW      = $clog2(A_DEPTH);
    localparam int DW      = $clog2(D_DEPTH);
    localparam int A_ENT_W = 122;
    localparam int D_ENT_W = 82;

    localparam logic [AW:0]   A_FULL_C  = (AW+1)'(A_DEPTH);
    localparam logic [DW:0]   D_FULL_C  = (DW+1)'(D_DEPTH);
    localparam logic [AW:0]   A_CNT_ONE = (AW+1)'(1);
    localparam logic [DW:0]   D_CNT_ONE = (DW+1)'(1);
    localparam logic [AW-1:0] A_PTR_ONE = AW'(1);
    localparam logic [DW-1:0] D_PTR_ONE = DW'(1);
    localparam logic [7:0]    MAX_INF   = 8'(MAX_INFLIGHT);

    logic [A_ENT_W-1:0] a_mem [A_DEPTH];
    logic [D_ENT_W-1:0] d_mem [D_DEPTH];
    logic [AW-1:0]      a_wr_ptr, a_rd_ptr;
    logic [DW-1:0]      d_wr_ptr, d_rd_ptr;
    logic [AW:0]        a_count, a_count_nxt;
    logic [DW:0]        d_count, d_count_nxt;
    logic               a_rdy_q, d_rdy_q;
    logic [7:0]         inflight, inflight_nxt;
    logic               a_enq, a_deq, d_enq, d_deq;
    logic               unused_sink;

    // The sink id carries no meaning upstream of the binder.
    assign unused_sink = auto_out_d_bits_sink;

    assign auto_in_a_ready  = a_rdy_q;
    assign auto_out_d_ready = d_rdy_q;
    assign auto_out_a_valid = (a_count != '0) && (inflight < MAX_INF);
    assign auto_in_d_valid  = (d_count != '0);
    assign inflight_count   = inflight;

    assign a_enq = auto_in_a_valid && a_rdy_q;
    assign a_deq = auto_out_a_valid && auto_out_a_ready;
    assign d_enq = auto_out_d_valid && d_rdy_q;
    assign d_deq = auto_in_d_valid && auto_in_d_ready;

    assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
            auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
            auto_out_a_bits_data} = a_mem[a_rd_ptr];
    assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
            auto_in_d_bits_source, auto_in_d_bits_denied, auto_in_d_bits_corrupt,
            auto_in_d_bits_data} = d_mem[d_rd_ptr];

    always_comb begin
        a_count_nxt = a_count;
        if (a_enq && !a_deq)      a_count_nxt = a_count + A_CNT_ONE;
        else if (!a_enq && a_deq) a_count_nxt = a_count - A_CNT_ONE;
        d_count_nxt = d_count;
        if (d_enq && !d_deq)      d_count_nxt = d_count + D_CNT_ONE;
        else if (!d_enq && d_deq) d_count_nxt = d_count - D_CNT_ONE;
        // A D beat arriving with nothing outstanding is a protocol error; hold at zero.
        inflight_nxt = inflight;
        if (a_deq && !d_deq)                        inflight_nxt = inflight + 8'd1;
        else if (!a_deq && d_deq && inflight != '0) inflight_nxt = inflight - 8'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            a_wr_ptr <= '0;
            a_rd_ptr <= '0;
            a_count  <= '0;
            a_rdy_q  <= 1'b0;
            d_wr_ptr <= '0;
            d_rd_ptr <= '0;
            d_count  <= '0;
            d_rdy_q  <= 1'b0;
            inflight <= '0;
        end else begin
            if (a_enq) a_wr_ptr <= a_wr_ptr + A_PTR_ONE;
            if (a_deq) a_rd_ptr <= a_rd_ptr + A_PTR_ONE;
            if (d_enq) d_wr_ptr <= d_wr_ptr + D_PTR_ONE;
            if (d_deq) d_rd_ptr <= d_rd_ptr + D_PTR_ONE;
            a_count  <= a_count_nxt;
            d_count  <= d_count_nxt;
            // Ready flags are registered from the next occupancy so they never depend on the far side.
            a_rdy_q  <= (a_count_nxt != A_FULL_C);
            d_rdy_q  <= (d_count_nxt != D_FULL_C);
            inflight <= inflight_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (a_enq)
            a_mem[a_wr_ptr] <= {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                                auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                                auto_in_a_bits_data};
        if (d_enq)
            d_mem[d_wr_ptr] <= {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                                auto_out_d_bits_source, auto_out_d_bits_denied, auto_out_d_bits_corrupt,
                                auto_out_d_bits_data};
    end

`ifdef TL_BANK_BUFFER_PERF_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_a_stall_cycles      <= '0;
            perf_inflight_cap_cycles <= '0;
        end else begin
            if (auto_out_a_valid && !auto_out_a_ready)
                perf_a_stall_cycles <= perf_a_stall_cycles + 32'd1;
            if ((a_count != '0) && (inflight == MAX_INF))
                perf_inflight_cap_cycles <= perf_inflight_cap_cycles + 32'd1;
        end
    end
`endif

endmodule
